sensor_sample_buf: RTL and testbench

// - Core of the sensor controller, one stage downstream of the AXI slave wrapper.
// - Takes enable, clear and word address from the wrapper and captures sensor_out samples into an on-chip buffer.
// - Asserts sctrl_interrupt when the buffer is full, and returns buffered words to the wrapper read path.

---
 rtl/sensor_sample_buf.sv | 122 ++++++++++++
 tb/tb_sensor_sample_buf.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_sample_buf.sv
// sensor_sample_buf: captures sensor samples into an on-chip word buffer,
// flags a full buffer on sctrl_interrupt and serves registered reads.
// Optional feature macro: SSB_OVF_CNT_EN enables the dropped-sample counter
// on ovf_cnt; when undefined ovf_cnt is constant zero and has no flops.
module sensor_sample_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic [ADDR_W-1:0] sctrl_addr,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out,
  output logic              sctrl_interrupt,
  output logic [DATA_W-1:0] sctrl_out,
  output logic              sensor_en,
  output logic [ADDR_W:0]   word_cnt,
  output logic [15:0]       ovf_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic              capture_c;
  logic [DATA_W-1:0] mem [DEPTH];

  // Sample request is a direct decode of the registered state, masked by clear.
  assign sensor_en = (state == CAPTURE) && !sctrl_clear;
  assign capture_c = sensor_en && sensor_ready;

  // Next-state logic; clear always returns to IDLE and blocks entry to CAPTURE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (sctrl_en && !sctrl_clear) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (sctrl_clear)                         state_nxt = IDLE;
        else if (capture_c && wptr == LAST_IDX)  state_nxt = FULL;
        else if (!sctrl_en)                      state_nxt = IDLE;
      end
      FULL: begin
        if (sctrl_clear) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Interrupt tracks the FULL state, registered from the next-state decode.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) sctrl_interrupt <= 1'b0;
    else          sctrl_interrupt <= (state_nxt == FULL);
  end

  // Write pointer and valid-word count; clear wins over a same-cycle capture.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wptr     <= '0;
      word_cnt <= '0;
    end else if (sctrl_clear) begin
      wptr     <= '0;
      word_cnt <= '0;
    end else if (capture_c) begin
      wptr <= wptr + ADDR_W'(1);
      if (word_cnt != FULL_CNT) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  // Sample storage; contents survive clear and are zeroed only by reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (capture_c) begin
      mem[wptr] <= sensor_out;
    end
  end

  // Registered read port; a same-edge write is seen on the following read.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) sctrl_out <= '0;
    else          sctrl_out <= mem[sctrl_addr];
  end

`ifdef SSB_OVF_CNT_EN
  logic [15:0] ovf_q;

  // Counts samples offered while the buffer is full, saturating.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)
      ovf_q <= 16'h0;
    else if (sctrl_clear)
      ovf_q <= 16'h0;
    else if (state == FULL && sensor_ready && ovf_q != 16'hFFFF)
      ovf_q <= ovf_q + 16'd1;
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_sensor_sample_buf.sv
// Self-checking bench for sensor_sample_buf: a queue-free behavioural model
// of the buffer is compared every cycle, plus directed literal expectations.
module tb_sensor_sample_buf;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_FULL = 2;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic              sctrl_en;
  logic              sctrl_clear;
  logic [ADDR_W-1:0] sctrl_addr;
  logic              sensor_ready;
  logic [DATA_W-1:0] sensor_out;
  logic              sctrl_interrupt;
  logic [DATA_W-1:0] sctrl_out;
  logic              sensor_en;
  logic [ADDR_W:0]   word_cnt;
  logic [15:0]       ovf_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  sensor_sample_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .ACLK            (ACLK),
    .ARESETn         (ARESETn),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_addr      (sctrl_addr),
    .sensor_ready    (sensor_ready),
    .sensor_out      (sensor_out),
    .sctrl_interrupt (sctrl_interrupt),
    .sctrl_out       (sctrl_out),
    .sensor_en       (sensor_en),
    .word_cnt        (word_cnt),
    .ovf_cnt         (ovf_cnt)
  );

  always #5 ACLK = ~ACLK;

  // Behavioural model state
  logic [31:0] m_buf [DEPTH];
  logic [31:0] m_rd;
  int          m_cnt;
  int          m_ptr;
  int          m_mode;
  logic [15:0] m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: buffer of DEPTH words, a count of captured words, and a mode.
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < int'(DEPTH); i++) m_buf[i] <= 32'h0;
      m_rd   <= 32'h0;
      m_cnt  <= 0;
      m_ptr  <= 0;
      m_mode <= M_IDLE;
      m_ovf  <= 16'h0;
    end else begin
      m_rd <= m_buf[sctrl_addr];
      if (sctrl_clear) begin
        m_cnt  <= 0;
        m_ptr  <= 0;
        m_mode <= M_IDLE;
        m_ovf  <= 16'h0;
      end else begin
        if (m_mode == M_FULL && sensor_ready && m_ovf != 16'hFFFF) m_ovf <= m_ovf + 16'd1;
        if (m_mode == M_CAP && sensor_ready) begin
          m_buf[m_ptr] <= sensor_out;
          m_cnt        <= m_cnt + 1;
          m_ptr        <= (m_ptr + 1) % int'(DEPTH);
          if (m_cnt + 1 == int'(DEPTH)) m_mode <= M_FULL;
          else if (!sctrl_en)           m_mode <= M_IDLE;
        end else if (m_mode == M_IDLE && sctrl_en) begin
          m_mode <= M_CAP;
        end else if (m_mode == M_CAP && !sctrl_en) begin
          m_mode <= M_IDLE;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge ACLK) begin
    if (ARESETn && cmp_on) begin
      check("cyc_interrupt", 32'(sctrl_interrupt), 32'(m_mode == M_FULL));
      check("cyc_sensor_en", 32'(sensor_en), 32'(m_mode == M_CAP && !sctrl_clear));
      check("cyc_word_cnt", 32'(word_cnt), 32'(m_cnt));
      check("cyc_sctrl_out", sctrl_out, m_rd);
`ifdef SSB_OVF_CNT_EN
      check("cyc_ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
`else
      check("cyc_ovf_cnt", 32'(ovf_cnt), 32'h0);
`endif
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic send(input logic [31:0] d);
    sensor_ready = 1'b1;
    sensor_out   = d;
    tick();
    sensor_ready = 1'b0;
  endtask

  task automatic read_chk(input string name, input int a, input logic [31:0] exp);
    sctrl_addr = ADDR_W'(a);
    tick();
    check(name, sctrl_out, exp);
  endtask

  initial begin
    ARESETn      = 1'b0;
    sctrl_en     = 1'b0;
    sctrl_clear  = 1'b0;
    sctrl_addr   = '0;
    sensor_ready = 1'b0;
    sensor_out   = '0;
    repeat (2) tick();
    check("rst_word_cnt", 32'(word_cnt), 32'h0);
    check("rst_interrupt", 32'(sctrl_interrupt), 32'h0);
    check("rst_sensor_en", 32'(sensor_en), 32'h0);
    check("rst_sctrl_out", sctrl_out, 32'h0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'h0);
    ARESETn = 1'b1;
    cmp_on  = 1'b1;
    tick();

    // Straight fill of 64 samples
    sctrl_en = 1'b1;
    tick();
    check("fill_sensor_en_on", 32'(sensor_en), 32'h1);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("fill_no_irq_before_last", 32'(sctrl_interrupt), 32'h0);
      send(32'h1000 + 32'(i));
    end
    sctrl_en = 1'b0;
    check("fill_interrupt", 32'(sctrl_interrupt), 32'h1);
    check("fill_word_cnt", 32'(word_cnt), 32'd64);
    check("fill_sensor_en_off", 32'(sensor_en), 32'h0);
    for (int i = 0; i < 64; i++) read_chk("fill_read", i, 32'h1000 + 32'(i));

    // Pause / resume
    sctrl_clear = 1'b1;
    tick();
    check("clr_interrupt", 32'(sctrl_interrupt), 32'h0);
    check("clr_word_cnt", 32'(word_cnt), 32'h0);
    sctrl_clear = 1'b0;
    sctrl_en    = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) send(32'h2000 + 32'(i));
    sctrl_en = 1'b0;
    repeat (5) tick();
    check("pause_word_cnt", 32'(word_cnt), 32'd20);
    check("pause_sensor_en", 32'(sensor_en), 32'h0);
    sctrl_en = 1'b1;
    tick();
    for (int i = 20; i < 64; i++) send(32'h2000 + 32'(i));
    sctrl_en = 1'b0;
    check("resume_interrupt", 32'(sctrl_interrupt), 32'h1);
    check("resume_word_cnt", 32'(word_cnt), 32'd64);
    for (int i = 0; i < 64; i++) read_chk("resume_read", i, 32'h2000 + 32'(i));

    // Clear racing a capture
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear = 1'b0;
    sctrl_en    = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send(32'h3000 + 32'(i));
    check("race_pre_cnt", 32'(word_cnt), 32'd3);
    sctrl_clear  = 1'b1;
    sensor_ready = 1'b1;
    sensor_out   = 32'hDEAD;
    tick();
    sctrl_clear  = 1'b0;
    sensor_ready = 1'b0;
    sctrl_en     = 1'b0;
    check("race_word_cnt", 32'(word_cnt), 32'h0);
    read_chk("race_buf3_kept", 3, 32'h2003);
    read_chk("race_buf0_kept", 0, 32'h3000);

    // Read-during-write to the same index
    sctrl_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send(32'h4000 + 32'(i));
    sctrl_addr   = ADDR_W'(5);
    sensor_ready = 1'b1;
    sensor_out   = 32'h4005;
    tick();
    sensor_ready = 1'b0;
    check("rdw_old_word", sctrl_out, 32'h2005);
    tick();
    check("rdw_new_word", sctrl_out, 32'h4005);

    // Overflow while full
    for (int i = 6; i < 64; i++) send(32'h6000 + 32'(i));
    check("ovf_full_irq", 32'(sctrl_interrupt), 32'h1);
    for (int i = 0; i < 7; i++) begin
      send(32'hBAD0 + 32'(i));
      tick();
    end
`ifdef SSB_OVF_CNT_EN
    check("ovf_count7", 32'(ovf_cnt), 32'd7);
`else
    check("ovf_tied0", 32'(ovf_cnt), 32'h0);
`endif
    check("ovf_word_cnt_sat", 32'(word_cnt), 32'd64);
    read_chk("ovf_buf63", 63, 32'h603F);
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear = 1'b0;
    check("ovf_clr_cnt", 32'(ovf_cnt), 32'h0);
    check("ovf_clr_irq", 32'(sctrl_interrupt), 32'h0);

    // Reset in the middle of a capture with 10 words stored
    sctrl_en = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) send(32'h5000 + 32'(i));
    check("mid_word_cnt", 32'(word_cnt), 32'd10);
    ARESETn = 1'b0;
    #1;
    check("arst_word_cnt", 32'(word_cnt), 32'h0);
    check("arst_interrupt", 32'(sctrl_interrupt), 32'h0);
    check("arst_sensor_en", 32'(sensor_en), 32'h0);
    check("arst_sctrl_out", sctrl_out, 32'h0);
    check("arst_ovf_cnt", 32'(ovf_cnt), 32'h0);
    tick();
    sctrl_en = 1'b0;
    ARESETn  = 1'b1;
    for (int i = 0; i < 64; i++) read_chk("arst_read_zero", i, 32'h0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
